// File: rtl/qei_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
//   gray_e  : filtered {A,B} level pair, Gray-ordered
//   step_e  : classification of one {A,B} transition
//   FILT_CNT_W : width of the per-pin glitch-filter down-counter
package qei_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } gray_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    ERR  = 2'd3
  } step_e;

  // Wide enough for the largest allowed filter length (15).
  localparam int FILT_CNT_W = 4;

  // Forward successor: S00 -> S01 -> S11 -> S10 -> S00.
  function automatic gray_e gray_fwd(input gray_e s);
    gray_e n;
    case (s)
      S00:     n = S01;
      S01:     n = S11;
      S11:     n = S10;
      default: n = S00;
    endcase
    return n;
  endfunction

  // A one-bit change is a legal step in one direction or the other;
  // a two-bit change cannot be attributed to either.
  function automatic step_e classify_step(input gray_e prev, input gray_e cur);
    step_e s;
    if (cur == prev)                s = NONE;
    else if (cur == gray_fwd(prev)) s = FWD;
    else if (prev == gray_fwd(cur)) s = REV;
    else                            s = ERR;
    return s;
  endfunction

endpackage

// File: rtl/qei_decoder_if.sv
// Control/status bundle between a host and qei_decoder.
//   master : host side, drives load/index/error controls, reads status
//   slave  : decoder side
// Parameter CNT_W sets the width of the position, index and velocity fields.
interface qei_decoder_if #(
  parameter int CNT_W = 32
);

  logic             pos_load;
  logic [CNT_W-1:0] pos_load_val;
  logic             index_en;
  logic             index_clr;
  logic             err_clr;

  logic [CNT_W-1:0] position;
  logic             direction;
  logic [CNT_W-1:0] index_pos;
  logic             index_valid;
  logic             err_sticky;
  logic [CNT_W-1:0] velocity;
  logic             vel_valid;

  modport master (
    output pos_load, pos_load_val, index_en, index_clr, err_clr,
    input  position, direction, index_pos, index_valid, err_sticky,
           velocity, vel_valid
  );

  modport slave (
    input  pos_load, pos_load_val, index_en, index_clr, err_clr,
    output position, direction, index_pos, index_valid, err_sticky,
           velocity, vel_valid
  );

endinterface

// File: rtl/qei_filter.sv
// One encoder pin: 2-flop synchronizer followed by a level filter that only
// moves its output after FILT_CYCLES consecutive synchronized samples that
// differ from the current output.
//   clk, reset_n : system clock, async active-low reset
//   din          : raw pin, asynchronous to clk
//   dout         : synchronized, filtered level
module qei_filter
  import qei_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam logic [FILT_CNT_W-1:0] CNT_RELOAD = FILT_CNT_W'(FILT_CYCLES - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  dout_q,  dout_d;
  logic [FILT_CNT_W-1:0] cnt_q,   cnt_d;

  // Down-counter holds the number of further differing samples still needed;
  // any sample equal to the output restarts the count.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dout_d  = dout_q;
    cnt_d   = CNT_RELOAD;
    if (sync2_q != dout_q) begin
      if (cnt_q == '0) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q - FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= CNT_RELOAD;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder interface decoder.
// Filters {A,B,Z}, tracks the {A,B} Gray state, keeps a wrapping signed
// position count, captures position on index, flags illegal transitions and,
// when built with QEI_VELOCITY_EN, reports net steps per VEL_PERIOD window.
// Without QEI_VELOCITY_EN, velocity and vel_valid are constant 0.
//   clk, reset_n : system clock, async active-low reset
//   enc_abz      : raw encoder pins {A,B,Z}
//   bus          : qei_decoder_if.slave control/status bundle
//
// state        | meaning
// -------------+--------------------------------------------------------
// (init_q = 0) | first cycle after reset: adopt filtered {A,B}, no step
// S00          | A=0 B=0
// S01          | A=0 B=1  (forward from S00)
// S11          | A=1 B=1  (forward from S01)
// S10          | A=1 B=0  (forward from S11, forward to S00)
module qei_decoder
  import qei_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int FILT_CYCLES = 4,
  parameter int VEL_PERIOD  = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [2:0]   enc_abz,
  qei_decoder_if.slave bus
);

  if (FILT_CYCLES < 1 || FILT_CYCLES > 15 || VEL_PERIOD < 1) begin : g_param_check
    $error("qei_decoder: FILT_CYCLES must be 1..15 and VEL_PERIOD >= 1");
  end

  logic filt_a, filt_b, filt_z;

  qei_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din(enc_abz[2]), .dout(filt_a)
  );
  qei_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din(enc_abz[1]), .dout(filt_b)
  );
  qei_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_z (
    .clk(clk), .reset_n(reset_n), .din(enc_abz[0]), .dout(filt_z)
  );

  gray_e            gray_q, gray_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] index_pos_q, index_pos_d;
  logic             index_valid_q, index_valid_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             z_prev_q, z_prev_d;

  step_e            step;
  logic [CNT_W-1:0] step_pos;
  logic             z_rise;

  always_comb begin
    gray_d        = gray_e'({filt_a, filt_b});
    init_d        = 1'b1;
    z_prev_d      = filt_z;
    step          = init_q ? classify_step(gray_q, gray_d) : NONE;

    step_pos      = pos_q;
    dir_d         = dir_q;
    case (step)
      FWD: begin
        step_pos = pos_q + CNT_W'(1);
        dir_d    = 1'b1;
      end
      REV: begin
        step_pos = pos_q - CNT_W'(1);
        dir_d    = 1'b0;
      end
      default: ;
    endcase

    z_rise        = filt_z & ~z_prev_q & bus.index_en;

    pos_d         = step_pos;
    if (z_rise && bus.index_clr) pos_d = '0;
    if (bus.pos_load)            pos_d = bus.pos_load_val;

    // Index capture reports where the encoder actually is (step applied),
    // even when the same edge clears the counter.
    index_pos_d   = z_rise ? step_pos : index_pos_q;
    index_valid_d = z_rise;

    // A coincident new error wins over the clear strobe.
    err_d         = (err_q & ~bus.err_clr) | (step == ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gray_q        <= S00;
      init_q        <= 1'b0;
      pos_q         <= '0;
      index_pos_q   <= '0;
      index_valid_q <= 1'b0;
      dir_q         <= 1'b0;
      err_q         <= 1'b0;
      z_prev_q      <= 1'b0;
    end else begin
      gray_q        <= gray_d;
      init_q        <= init_d;
      pos_q         <= pos_d;
      index_pos_q   <= index_pos_d;
      index_valid_q <= index_valid_d;
      dir_q         <= dir_d;
      err_q         <= err_d;
      z_prev_q      <= z_prev_d;
    end
  end

  assign bus.position    = pos_q;
  assign bus.direction   = dir_q;
  assign bus.index_pos   = index_pos_q;
  assign bus.index_valid = index_valid_q;
  assign bus.err_sticky  = err_q;

`ifdef QEI_VELOCITY_EN
  localparam int               WIN_W    = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] vel_q, vel_d;
  logic             vel_valid_q, vel_valid_d;
  logic [CNT_W-1:0] step_delta;
  logic             win_end;

  // Only legal encoder steps count; loads and index clears do not move the
  // accumulator. The step landing on the window boundary opens the next one.
  always_comb begin
    case (step)
      FWD:     step_delta = CNT_W'(1);
      REV:     step_delta = '1;
      default: step_delta = '0;
    endcase
    win_end     = (win_q == WIN_LAST);
    win_d       = win_end ? '0 : win_q + WIN_W'(1);
    acc_d       = win_end ? step_delta : acc_q + step_delta;
    vel_d       = win_end ? acc_q : vel_q;
    vel_valid_d = win_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      acc_q       <= acc_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign bus.velocity  = vel_q;
  assign bus.vel_valid = vel_valid_q;
`else
  assign bus.velocity  = '0;
  assign bus.vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qei_decoder.sv
module tb_qei_decoder;

  localparam int CNT_W = 16;
  localparam int FILT  = 4;
  localparam int VEL   = 1000;
  localparam int LAT   = FILT + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] enc_abz;

  always #5 clk = ~clk;

  qei_decoder_if #(.CNT_W(CNT_W)) bus ();

  qei_decoder #(
    .CNT_W(CNT_W), .FILT_CYCLES(FILT), .VEL_PERIOD(VEL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enc_abz(enc_abz), .bus(bus.slave)
  );

  int               checks = 0;
  int               errors = 0;
  int               ncyc   = 0;
  int               net_steps;
  logic [1:0]       ab_cur;
  logic [CNT_W-1:0] exp_pos;
  logic [CNT_W-1:0] base;
  string            sb_tag[$];
  logic [31:0]      sb_val[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic sb_pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] v;
    if (sb_val.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<entry>", obs);
    end else begin
      t = sb_tag.pop_front();
      v = sb_val.pop_front();
      chk(t, obs, v);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Drive new {A,B} and advance the reference position model.
  task automatic drive_ab(input logic [1:0] ab);
    if (ab == fwd_of(ab_cur)) begin
      exp_pos = exp_pos + 1'b1;
      net_steps++;
    end else if (ab_cur == fwd_of(ab)) begin
      exp_pos = exp_pos - 1'b1;
      net_steps--;
    end
    enc_abz[2:1] = ab;
    ab_cur       = ab;
  endtask

  initial begin
    reset_n          = 1'b0;
    enc_abz          = 3'b000;
    bus.pos_load     = 1'b0;
    bus.pos_load_val = '0;
    bus.index_en     = 1'b0;
    bus.index_clr    = 1'b0;
    bus.err_clr      = 1'b0;
    ab_cur           = 2'b00;
    exp_pos          = '0;
    net_steps        = 0;

    tick(3);
    chk("rst_position",    32'(bus.position),    0);
    chk("rst_direction",   32'(bus.direction),   0);
    chk("rst_err",         32'(bus.err_sticky),  0);
    chk("rst_index_pos",   32'(bus.index_pos),   0);
    chk("rst_index_valid", 32'(bus.index_valid), 0);
    chk("rst_velocity",    32'(bus.velocity),    0);
    chk("rst_vel_valid",   32'(bus.vel_valid),   0);
    reset_n = 1'b1;
    tick(5);

    // 8 forward quadrature cycles, 200 clocks per edge
    for (int i = 0; i < 32; i++) begin
      drive_ab(fwd_of(ab_cur));
      sb_push($sformatf("fwd_step%0d", i), 32'(exp_pos));
      if (i == 0) begin
        tick(LAT - 1);
        chk("latency_early", 32'(bus.position), 0);
        tick(1);
        sb_pop_chk(32'(bus.position));
        tick(200 - LAT);
      end else begin
        tick(200);
        sb_pop_chk(32'(bus.position));
      end
    end
    chk("fwd_direction", 32'(bus.direction),  1);
    chk("fwd_err",       32'(bus.err_sticky), 0);

    // Glitch on A one sample too short: filtered away
    base = exp_pos;
    sb_push("glitch_short", 32'(exp_pos));
    tick(1);
    enc_abz[2] = 1'b1;
    tick(FILT - 1);
    enc_abz[2] = 1'b0;
    tick(20);
    sb_pop_chk(32'(bus.position));

    // Glitch exactly FILT long: accepted as a reverse step, then undone
    tick(1);
    drive_ab(2'b10);
    sb_push("glitch_long_step", 32'(exp_pos));
    tick(FILT);
    drive_ab(2'b00);
    sb_push("glitch_long_back", 32'(exp_pos));
    tick(2);
    chk("glitch_long_early", 32'(bus.position), 32'(base));
    tick(1);
    sb_pop_chk(32'(bus.position));
    tick(20);
    sb_pop_chk(32'(bus.position));
    chk("glitch_long_dir", 32'(bus.direction), 1);

    // Wrap in both directions
    tick(1);
    bus.pos_load     = 1'b1;
    bus.pos_load_val = '0;
    exp_pos          = '0;
    sb_push("load_zero", 0);
    tick(1);
    bus.pos_load = 1'b0;
    tick(1);
    sb_pop_chk(32'(bus.position));
    drive_ab(2'b10);
    sb_push("wrap_rev", 32'(exp_pos));
    tick(LAT + 5);
    sb_pop_chk(32'(bus.position));
    chk("wrap_rev_dir", 32'(bus.direction), 0);

    bus.pos_load     = 1'b1;
    bus.pos_load_val = '1;
    exp_pos          = '1;
    tick(1);
    bus.pos_load = 1'b0;
    drive_ab(2'b00);
    sb_push("wrap_fwd", 32'(exp_pos));
    tick(LAT + 5);
    sb_pop_chk(32'(bus.position));
    chk("wrap_fwd_dir", 32'(bus.direction), 1);

    // A and B change together: error, no count, state adopted
    tick(1);
    drive_ab(2'b11);
    sb_push("illegal_pos", 32'(exp_pos));
    tick(LAT - 1);
    chk("illegal_err_early", 32'(bus.err_sticky), 0);
    tick(1);
    chk("illegal_err", 32'(bus.err_sticky), 1);
    sb_pop_chk(32'(bus.position));
    chk("illegal_dir", 32'(bus.direction), 1);
    tick(1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("err_cleared", 32'(bus.err_sticky), 0);

    // Index with clear, coincident with a forward step at 100
    bus.index_en     = 1'b1;
    bus.index_clr    = 1'b1;
    bus.pos_load     = 1'b1;
    bus.pos_load_val = CNT_W'(100);
    exp_pos          = CNT_W'(100);
    tick(1);
    bus.pos_load = 1'b0;
    drive_ab(2'b10);
    enc_abz[0] = 1'b1;
    sb_push("index_pos", 32'(exp_pos));
    exp_pos = '0;
    sb_push("index_clr_pos", 32'(exp_pos));
    tick(LAT - 1);
    chk("index_pos_early",   32'(bus.position),    100);
    chk("index_valid_early", 32'(bus.index_valid), 0);
    tick(1);
    sb_pop_chk(32'(bus.index_pos));
    sb_pop_chk(32'(bus.position));
    chk("index_valid_pulse", 32'(bus.index_valid), 1);
    tick(1);
    chk("index_valid_end", 32'(bus.index_valid), 0);

    // Z edge ignored while index_en is low
    bus.index_en = 1'b0;
    enc_abz[0]   = 1'b0;
    tick(LAT + 3);
    enc_abz[0] = 1'b1;
    tick(LAT);
    chk("index_off_valid", 32'(bus.index_valid), 0);
    chk("index_off_pos",   32'(bus.index_pos),   101);
    chk("index_off_clr",   32'(bus.position),    0);

    // Index capture without clear
    bus.index_en  = 1'b1;
    bus.index_clr = 1'b0;
    enc_abz[0]    = 1'b0;
    tick(LAT + 3);
    enc_abz[0] = 1'b1;
    tick(LAT);
    chk("index_noclr_valid", 32'(bus.index_valid), 1);
    chk("index_noclr_pos",   32'(bus.index_pos),   0);

    // Reset mid-window, then 25 forward steps inside the first window
    tick(1);
    reset_n       = 1'b0;
    enc_abz       = 3'b000;
    ab_cur        = 2'b00;
    exp_pos       = '0;
    net_steps     = 0;
    bus.index_en  = 1'b0;
    tick(2);
    chk("rst2_position",  32'(bus.position),  0);
    chk("rst2_index_pos", 32'(bus.index_pos), 0);
    reset_n = 1'b1;
    ncyc    = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      drive_ab(fwd_of(ab_cur));
      tick(29);
    end
    sb_push("vel_pos", 32'(exp_pos));
`ifdef QEI_VELOCITY_EN
    sb_push("velocity", 32'(net_steps));
`else
    sb_push("velocity", 0);
`endif
    sb_pop_chk(32'(bus.position));
    tick(VEL - 1 - ncyc);
    chk("vel_valid_before", 32'(bus.vel_valid), 0);
    tick(1);
    sb_pop_chk(32'(bus.velocity));
`ifdef QEI_VELOCITY_EN
    chk("vel_valid_pulse", 32'(bus.vel_valid), 1);
`else
    chk("vel_valid_pulse", 32'(bus.vel_valid), 0);
`endif
    tick(1);
    chk("vel_valid_after", 32'(bus.vel_valid), 0);

    chk("sb_drained", 32'(sb_val.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
